// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes the raw lock flag, sequences a clean release of sys_reset_n
// and keeps loss status. Define PLL_LOCK_SUPERVISOR_TIMEOUT_EN to build the lock-timeout monitor.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   locked,
  input  logic                   clear_status,
  output logic                   sys_reset_n,
  output logic                   ready,
  output logic                   lost,
  output logic [COUNT_WIDTH-1:0] loss_count,
  output logic                   timeout
);

  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] STABLE    = 3'd1;
  localparam logic [2:0] HOLD      = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] LOST      = 3'd4;

  localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  logic [2:0]             state;
  logic [2:0]             next_state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = sync[SYNC_STAGES-1];

  // Any drop of locked_s before RUN restarts qualification; STABLE exits one cycle
  // after its count reaches the terminal value, HOLD exits as its count reaches it.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (locked_s) begin
          next_state = STABLE;
          cnt_next   = CNT_W'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_TERM) begin
          next_state = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == HOLD_LAST) begin
          next_state = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!locked_s) begin
          next_state = LOST;
        end
      end
      LOST: begin
        next_state = WAIT_LOCK;
        cnt_next   = '0;
      end
      default: begin
        next_state = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they track RUN without an extra cycle of lag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      sys_reset_n <= (next_state == RUN);
      ready       <= (next_state == RUN);
    end
  end

  // A clear in the same cycle as a loss is applied first, so that loss is still recorded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lost       <= 1'b0;
      loss_count <= '0;
    end else begin
      if (clear_status) begin
        lost       <= 1'b0;
        loss_count <= '0;
      end
      if (state == LOST) begin
        lost <= 1'b1;
        if (clear_status) begin
          loss_count <= COUNT_WIDTH'(1);
        end else if (loss_count != '1) begin
          loss_count <= loss_count + COUNT_WIDTH'(1);
        end
      end
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_counting;

  assign tmo_counting = (state == WAIT_LOCK) || (state == STABLE) || (state == HOLD);

  // The timer spans the whole acquisition attempt, so glitches back to WAIT_LOCK do not restart it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == LOST || next_state == RUN) begin
        tmo_cnt <= '0;
      end else if (tmo_counting && tmo_cnt != TMO_TERM) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (clear_status) begin
        timeout <= 1'b0;
      end
      if (tmo_counting && tmo_cnt == TMO_LAST) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  // Constant 0; the comparison only keeps TIMEOUT_CYCLES referenced in this build.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pll_lock_supervisor;

  localparam int CW = 2;
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          locked;
  logic          clear_status;
  logic          sys_reset_n;
  logic          ready;
  logic          lost;
  logic [CW-1:0] loss_count;
  logic          timeout;

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES(50),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .locked      (locked),
    .clear_status(clear_status),
    .sys_reset_n (sys_reset_n),
    .ready       (ready),
    .lost        (lost),
    .loss_count  (loss_count),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            at;
    string         name;
    logic          srn;
    logic          rdy;
    logic          lst;
    logic [CW-1:0] cnt;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input int at, input logic srn, input logic rdy,
                             input logic lst, input logic [CW-1:0] cnt, input logic tmo);
    exp_t e;
    e.at   = at;
    e.name = name;
    e.srn  = srn;
    e.rdy  = rdy;
    e.lst  = lst;
    e.cnt  = cnt;
    e.tmo  = tmo;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic rst, input logic lk, input logic clr);
    reset_n      = rst;
    locked       = lk;
    clear_status = clr;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Monitor: every negedge, compare all expectations stamped for the edge just taken.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.at != cyc || sys_reset_n !== e.srn || ready !== e.rdy || lost !== e.lst ||
          loss_count !== e.cnt || timeout !== e.tmo) begin
        errors++;
        $display("[TB] FAIL %s @edge %0d (checked %0d): got srn=%b rdy=%b lost=%b cnt=%0d tmo=%b, want srn=%b rdy=%b lost=%b cnt=%0d tmo=%b",
                 e.name, e.at, cyc, sys_reset_n, ready, lost, loss_count, timeout,
                 e.srn, e.rdy, e.lst, e.cnt, e.tmo);
      end
    end
  end

  // One lock loss from RUN followed by relock; clr pulses clear_status on the LOST edge.
  task automatic lossCycle(input logic lst_before, input logic [CW-1:0] cnt_before,
                           input logic [CW-1:0] cnt_after, input logic clr);
    int base;
    int b2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    base = cyc;
    checkOutput("loss_still_run", base + 2, 1'b1, 1'b1, lst_before, cnt_before, 1'b0);
    checkOutput("loss_drop",      base + 3, 1'b0, 1'b0, lst_before, cnt_before, 1'b0);
    checkOutput("loss_status",    base + 4, 1'b0, 1'b0, 1'b1,       cnt_after,  1'b0);
    if (clr) begin
      step(3);
      applyStimulus(1'b1, 1'b0, 1'b1);
      step(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      step(6);
    end else begin
      step(10);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    b2 = cyc;
    checkOutput("relock_hold",    b2 + 14, 1'b0, 1'b0, 1'b1, cnt_after, 1'b0);
    checkOutput("relock_release", b2 + 15, 1'b1, 1'b1, 1'b1, cnt_after, 1'b0);
    step(18);
  endtask

  initial begin
    int base;
    int b2;
    int wait_cycles;

    // Reset with lock already present, then a clean release
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(3);
    checkOutput("reset_state", cyc + 1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    base = cyc;
    checkOutput("clean_hold",    base + 14, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("clean_release", base + 15, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    step(20);

    // Losses up to saturation, then a clear coincident with the fifth loss
    lossCycle(1'b0, 2'd0, 2'd1, 1'b0);
    lossCycle(1'b1, 2'd1, 2'd2, 1'b0);
    lossCycle(1'b1, 2'd2, 2'd3, 1'b0);
    lossCycle(1'b1, 2'd3, 2'd3, 1'b0);
    lossCycle(1'b1, 2'd3, 2'd1, 1'b1);

    // A lone clear in RUN wipes status but leaves the reset output alone
    checkOutput("clear_in_run", cyc + 1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(3);
    lossCycle(1'b0, 2'd0, 2'd1, 1'b0);

    // Asynchronous reset in the middle of RUN
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("async_reset", cyc, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);

    // Glitch during STABLE restarts the sequence
    applyStimulus(1'b1, 1'b1, 1'b0);
    base = cyc;
    checkOutput("glitch_no_release", base + 15, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    b2 = cyc;
    checkOutput("glitch_hold",    b2 + 14, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("glitch_release", b2 + 15, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    step(20);

    // Timeout while lock stays away
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    base = cyc;
    checkOutput("tmo_before", base + 49, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("tmo_set",    base + 50, 1'b0, 1'b0, 1'b0, 2'd0, TMO_EN);
    step(60);
    applyStimulus(1'b1, 1'b1, 1'b0);
    b2 = cyc;
    checkOutput("tmo_persist", b2 + 15, 1'b1, 1'b1, 1'b0, 2'd0, TMO_EN);
    step(16);
    checkOutput("tmo_cleared", cyc + 1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 50) begin
      step(1);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded, want completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
